// File: rtl/drive_pkg.sv
// rtl/drive_pkg.sv - shared types, IR button codes and duty targets for drive_mode_ctrl
// Purpose: enums for top-level mode, CAM sub-state and drive command; IR code map;
// drive-command to target-duty mapping. No ports.
package drive_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_CAM  = 2'b01,
        MODE_IR   = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        CAM_SEARCH = 2'b00,
        CAM_FOLLOW = 2'b01,
        CAM_PAUSE  = 2'b11
    } cam_state_t;

    typedef enum logic [3:0] {
        DRV_STOP     = 4'd0,
        DRV_LEFT     = 4'd1,
        DRV_RIGHT    = 4'd2,
        DRV_SLOW     = 4'd3,
        DRV_MEDIUM   = 4'd4,
        DRV_FAST     = 4'd5,
        DRV_REVERSE  = 4'd6,
        DRV_LREVERSE = 4'd7,
        DRV_RREVERSE = 4'd8,
        DRV_HARD_L   = 4'd9,
        DRV_HARD_R   = 4'd10
    } drive_state_t;

    typedef struct packed {
        logic         hit;
        drive_state_t cmd;
    } ir_cmd_t;

    // Mode-select buttons
    localparam logic [7:0] IR_CODE_CAM  = 8'h0F;
    localparam logic [7:0] IR_CODE_IR   = 8'h13;
    localparam logic [7:0] IR_CODE_IDLE = 8'h10;

    // Motion buttons
    localparam logic [7:0] IR_CODE_STOP     = 8'h0C;
    localparam logic [7:0] IR_CODE_LEFT     = 8'h07;
    localparam logic [7:0] IR_CODE_RIGHT    = 8'h09;
    localparam logic [7:0] IR_CODE_FAST     = 8'h02;
    localparam logic [7:0] IR_CODE_MEDIUM   = 8'h05;
    localparam logic [7:0] IR_CODE_SLOW     = 8'h08;
    localparam logic [7:0] IR_CODE_REVERSE  = 8'h00;
    localparam logic [7:0] IR_CODE_LREVERSE = 8'h11;
    localparam logic [7:0] IR_CODE_RREVERSE = 8'h17;

    function automatic ir_cmd_t ir_cmd_lookup(input logic [7:0] code);
        ir_cmd_t r;
        r.hit = 1'b1;
        r.cmd = DRV_STOP;
        case (code)
            IR_CODE_STOP:     r.cmd = DRV_STOP;
            IR_CODE_LEFT:     r.cmd = DRV_LEFT;
            IR_CODE_RIGHT:    r.cmd = DRV_RIGHT;
            IR_CODE_FAST:     r.cmd = DRV_FAST;
            IR_CODE_MEDIUM:   r.cmd = DRV_MEDIUM;
            IR_CODE_SLOW:     r.cmd = DRV_SLOW;
            IR_CODE_REVERSE:  r.cmd = DRV_REVERSE;
            IR_CODE_LREVERSE: r.cmd = DRV_LREVERSE;
            IR_CODE_RREVERSE: r.cmd = DRV_RREVERSE;
            default:          r.hit = 1'b0;
        endcase
        return r;
    endfunction

    // Target duty for a drive command at a duty width of w bits (w <= 16).
    function automatic logic [15:0] target_duty(input drive_state_t d, input int unsigned w);
        logic [15:0] max_v;
        max_v = 16'((32'd1 << w) - 32'd1);
        case (d)
            DRV_STOP:   return 16'd0;
            DRV_SLOW:   return max_v >> 2;
            DRV_MEDIUM: return max_v >> 1;
            DRV_FAST:   return max_v;
            default:    return max_v >> 1;
        endcase
    endfunction

endpackage

// File: rtl/duty_ramp.sv
// rtl/duty_ramp.sv - rate-limited motor duty with immediate stop
// Ports: clk_i, rst_ni (async active-low), target_i (duty target), stop_i (force 0 next
// cycle), duty_o (registered ramped duty).
module duty_ramp #(
    parameter int unsigned DUTY_W    = 8,
    parameter int unsigned RAMP_DIV  = 50_000,
    parameter int unsigned RAMP_STEP = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DUTY_W-1:0] target_i,
    input  logic              stop_i,
    output logic [DUTY_W-1:0] duty_o
);

    localparam int unsigned       DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RAMP_DIV - 1);
    localparam logic [DUTY_W-1:0] STEP     = DUTY_W'(RAMP_STEP);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              tick;

    // Free-running divider: only reset clears it, so ramp phase is independent of target changes.
    assign tick  = (div_q == DIV_LAST);
    assign div_d = tick ? '0 : div_q + 1'b1;

    always_comb begin
        duty_d = duty_q;
        if (stop_i) begin
            duty_d = '0;
        end else if (tick) begin
            // Compare the remaining distance first so the step lands exactly on target.
            if (duty_q < target_i) begin
                duty_d = ((target_i - duty_q) <= STEP) ? target_i : duty_q + STEP;
            end else if (duty_q > target_i) begin
                duty_d = ((duty_q - target_i) <= STEP) ? target_i : duty_q - STEP;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= '0;
            duty_q <= '0;
        end else begin
            div_q  <= div_d;
            duty_q <= duty_d;
        end
    end

    assign duty_o = duty_q;

endmodule

// File: rtl/drive_mode_ctrl.sv
// rtl/drive_mode_ctrl.sv - robot mode arbiter, CAM tracker sub-FSM and drive command generator
// Ports: clk_50, reset_n (async active-low); ir_valid/ir_code from IR decoder;
// cam_dir/cam_speed/orange_detected from camera tracker; mode, cam_state, drive_state,
// mode_change (one-cycle pulse), duty (ramped) to the motor stage.
import drive_pkg::*;

module drive_mode_ctrl #(
    parameter int unsigned CMD_HOLD_CYCLES       = 25_000_000,
    parameter int unsigned LOST_GRACE_CYCLES     = 5_000_000,
    parameter int unsigned SEARCH_TIMEOUT_CYCLES = 250_000_000,
    parameter int unsigned DUTY_W                = 8,
    parameter int unsigned RAMP_DIV              = 50_000,
    parameter int unsigned RAMP_STEP             = 4
) (
    input  logic              clk_50,
    input  logic              reset_n,
    input  logic              ir_valid,
    input  logic [7:0]        ir_code,
    input  logic [2:0]        cam_dir,
    input  logic [1:0]        cam_speed,
    input  logic              orange_detected,
    output logic [1:0]        mode,
    output logic [1:0]        cam_state,
    output logic [3:0]        drive_state,
    output logic              mode_change,
    output logic [DUTY_W-1:0] duty
);

    localparam int unsigned HOLD_W   = $clog2(CMD_HOLD_CYCLES + 1);
    localparam int unsigned LOST_W   = $clog2(LOST_GRACE_CYCLES + 1);
    localparam int unsigned SEARCH_W = $clog2(SEARCH_TIMEOUT_CYCLES + 1);

    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(CMD_HOLD_CYCLES - 1);
    localparam logic [LOST_W-1:0]   LOST_LAST   = LOST_W'(LOST_GRACE_CYCLES - 1);
    localparam logic [SEARCH_W-1:0] SEARCH_LAST = SEARCH_W'(SEARCH_TIMEOUT_CYCLES - 1);

    mode_t                mode_q, mode_d;
    cam_state_t           cam_q, cam_d;
    drive_state_t         drive_q, drive_d;
    drive_state_t         ir_cmd_q, ir_cmd_d;
    logic                 mode_change_q, mode_change_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [LOST_W-1:0]    lost_cnt_q, lost_cnt_d;
    logic [SEARCH_W-1:0]  search_cnt_q, search_cnt_d;
    logic                 enter_cam, enter_ir;
    ir_cmd_t              ir_hit;
    logic [DUTY_W-1:0]    target;

    // Top-level mode: only strobed mode buttons move it.
    always_comb begin
        mode_d = mode_q;
        if (ir_valid) begin
            case (ir_code)
                IR_CODE_CAM:  mode_d = MODE_CAM;
                IR_CODE_IR:   mode_d = MODE_IR;
                IR_CODE_IDLE: mode_d = MODE_IDLE;
                default:      mode_d = mode_q;
            endcase
        end
    end

    assign enter_cam = (mode_d == MODE_CAM) && (mode_q != MODE_CAM);
    assign enter_ir  = (mode_d == MODE_IR)  && (mode_q != MODE_IR);

    // CAM sub-state. Mode entry/exit outranks detection; counters only advance while
    // the FSM stays in the state they time, and the transition fires at the last count,
    // so they cannot pass their limit.
    always_comb begin
        cam_d        = cam_q;
        search_cnt_d = '0;
        lost_cnt_d   = '0;
        if (mode_d != MODE_CAM) begin
            cam_d = CAM_PAUSE;
        end else if (enter_cam) begin
            cam_d = CAM_SEARCH;
        end else begin
            case (cam_q)
                CAM_SEARCH: begin
                    if (orange_detected)             cam_d = CAM_FOLLOW;
                    else if (search_cnt_q == SEARCH_LAST) cam_d = CAM_PAUSE;
                    else                             search_cnt_d = search_cnt_q + 1'b1;
                end
                CAM_FOLLOW: begin
                    if (orange_detected)             cam_d = CAM_FOLLOW;
                    else if (lost_cnt_q == LOST_LAST) cam_d = CAM_SEARCH;
                    else                             lost_cnt_d = lost_cnt_q + 1'b1;
                end
                CAM_PAUSE: begin
                    if (orange_detected) cam_d = CAM_FOLLOW;
                end
                default: cam_d = CAM_PAUSE;
            endcase
        end
    end

    // IR command latch with dead-man hold timer.
    assign ir_hit = ir_cmd_lookup(ir_code);

    always_comb begin
        ir_cmd_d   = ir_cmd_q;
        hold_cnt_d = hold_cnt_q;
        if (mode_d != MODE_IR || enter_ir) begin
            ir_cmd_d   = DRV_STOP;
            hold_cnt_d = '0;
        end else if (ir_valid && ir_hit.hit) begin
            ir_cmd_d   = ir_hit.cmd;
            hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
            ir_cmd_d = DRV_STOP;
        end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    // Drive command is derived from the next-state values so it moves in the same
    // cycle as mode/cam_state.
    always_comb begin
        drive_d = DRV_STOP;
        case (mode_d)
            MODE_CAM: begin
                if (cam_speed == 2'b11) begin
                    drive_d = DRV_STOP;
                end else if (cam_d != CAM_PAUSE && cam_dir == 3'b001) begin
                    drive_d = DRV_LEFT;
                end else if (cam_d != CAM_PAUSE && cam_dir == 3'b010) begin
                    drive_d = DRV_RIGHT;
                end else if (cam_d == CAM_FOLLOW && cam_dir == 3'b011) begin
                    case (cam_speed)
                        2'b00:   drive_d = DRV_SLOW;
                        2'b01:   drive_d = DRV_MEDIUM;
                        default: drive_d = DRV_FAST;
                    endcase
                end
            end
            MODE_IR: begin
                if (cam_speed == 2'b11) begin
                    drive_d = DRV_STOP;
                end else if (orange_detected && cam_dir == 3'b010) begin
                    drive_d = DRV_HARD_L;
                end else if (orange_detected && cam_dir == 3'b001) begin
                    drive_d = DRV_HARD_R;
                end else if (orange_detected && cam_dir == 3'b011) begin
                    drive_d = DRV_REVERSE;
                end else begin
                    drive_d = ir_cmd_d;
                end
            end
            default: drive_d = DRV_STOP;
        endcase
    end

    assign mode_change_d = (mode_d != mode_q) || (cam_d != cam_q);

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            mode_q        <= MODE_IDLE;
            cam_q         <= CAM_PAUSE;
            drive_q       <= DRV_STOP;
            ir_cmd_q      <= DRV_STOP;
            mode_change_q <= 1'b0;
            hold_cnt_q    <= '0;
            lost_cnt_q    <= '0;
            search_cnt_q  <= '0;
        end else begin
            mode_q        <= mode_d;
            cam_q         <= cam_d;
            drive_q       <= drive_d;
            ir_cmd_q      <= ir_cmd_d;
            mode_change_q <= mode_change_d;
            hold_cnt_q    <= hold_cnt_d;
            lost_cnt_q    <= lost_cnt_d;
            search_cnt_q  <= search_cnt_d;
        end
    end

    assign target = DUTY_W'(target_duty(drive_q, DUTY_W));

    duty_ramp #(
        .DUTY_W    (DUTY_W),
        .RAMP_DIV  (RAMP_DIV),
        .RAMP_STEP (RAMP_STEP)
    ) u_duty_ramp (
        .clk_i    (clk_50),
        .rst_ni   (reset_n),
        .target_i (target),
        .stop_i   (drive_q == DRV_STOP),
        .duty_o   (duty)
    );

    assign mode        = mode_q;
    assign cam_state   = cam_q;
    assign drive_state = drive_q;
    assign mode_change = mode_change_q;

endmodule

// File: tb/tb_drive_mode_ctrl.sv
// tb/tb_drive_mode_ctrl.sv - scoreboard bench for drive_mode_ctrl
module tb_drive_mode_ctrl;

    localparam int unsigned HOLD   = 16;
    localparam int unsigned LOST   = 8;
    localparam int unsigned SRCH   = 32;
    localparam int unsigned DW     = 8;
    localparam int unsigned DIV    = 4;
    localparam int unsigned STEP   = 4;

    localparam int M_IDLE = 0, M_CAM = 1, M_IR = 2;
    localparam int C_SEARCH = 0, C_FOLLOW = 1, C_PAUSE = 3;
    localparam int D_STOP = 0, D_LEFT = 1, D_RIGHT = 2, D_SLOW = 3, D_MEDIUM = 4, D_FAST = 5;
    localparam int D_REVERSE = 6, D_HARD_L = 9, D_HARD_R = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ir_valid;
    logic [7:0]    ir_code;
    logic [2:0]    cam_dir;
    logic [1:0]    cam_speed;
    logic          orange;
    logic [1:0]    mode;
    logic [1:0]    cam_state;
    logic [3:0]    drive_state;
    logic          mode_change;
    logic [DW-1:0] duty;

    typedef struct {
        int mode;
        int cam;
        int drv;
        int mc;
        int duty;
        bit duty_vld;
    } exp_t;

    exp_t sb_q[$];
    int   ramp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   prev_duty, gap;
    bit   first;

    drive_mode_ctrl #(
        .CMD_HOLD_CYCLES       (HOLD),
        .LOST_GRACE_CYCLES     (LOST),
        .SEARCH_TIMEOUT_CYCLES (SRCH),
        .DUTY_W                (DW),
        .RAMP_DIV              (DIV),
        .RAMP_STEP             (STEP)
    ) dut (
        .clk_50          (clk),
        .reset_n         (rst_n),
        .ir_valid        (ir_valid),
        .ir_code         (ir_code),
        .cam_dir         (cam_dir),
        .cam_speed       (cam_speed),
        .orange_detected (orange),
        .mode            (mode),
        .cam_state       (cam_state),
        .drive_state     (drive_state),
        .mode_change     (mode_change),
        .duty            (duty)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [7:0] code, input logic [2:0] dir,
                          input logic [1:0] spd, input logic org);
        ir_valid  = v;
        ir_code   = code;
        cam_dir   = dir;
        cam_speed = spd;
        orange    = org;
    endtask

    task automatic push(input int m, input int c, input int d, input int mc, input int du,
                        input bit dv);
        exp_t e;
        e.mode = m; e.cam = c; e.drv = d; e.mc = mc; e.duty = du; e.duty_vld = dv;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input string lbl);
        exp_t e;
        e = sb_q.pop_front();
        check_eq({lbl, ".mode"}, int'(mode), e.mode);
        check_eq({lbl, ".cam"}, int'(cam_state), e.cam);
        check_eq({lbl, ".drive"}, int'(drive_state), e.drv);
        check_eq({lbl, ".mc"}, int'(mode_change), e.mc);
        if (e.duty_vld) check_eq({lbl, ".duty"}, int'(duty), e.duty);
    endtask

    // Expectation for the state after the next clock edge.
    task automatic tick(input string lbl, input int m, input int c, input int d, input int mc,
                        input int du, input bit dv);
        push(m, c, d, mc, du, dv);
        @(posedge clk);
        #1;
        pop_cmp(lbl);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 8'h00, 3'b000, 2'b00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        push(M_IDLE, C_PAUSE, D_STOP, 0, 0, 1);
        pop_cmp("reset");
        rst_n = 1'b1;

        // Enter CAM: one-cycle pulse, then same-mode code gives no pulse
        set_in(1'b1, 8'h0F, 3'b000, 2'b00, 1'b0);
        tick("cam_enter", M_CAM, C_SEARCH, D_STOP, 1, 0, 1);
        set_in(1'b0, 8'h0F, 3'b000, 2'b00, 1'b0);
        tick("cam_pulse_end", M_CAM, C_SEARCH, D_STOP, 0, 0, 1);
        set_in(1'b1, 8'h0F, 3'b000, 2'b00, 1'b0);
        tick("cam_same", M_CAM, C_SEARCH, D_STOP, 0, 0, 1);

        // FOLLOW + FAST, duty ramp to full scale
        set_in(1'b0, 8'h00, 3'b011, 2'b10, 1'b1);
        for (int v = 4; v < 255; v += 4) ramp_q.push_back(v);
        ramp_q.push_back(255);
        tick("follow_fast", M_CAM, C_FOLLOW, D_FAST, 1, 0, 1);
        prev_duty = int'(duty);
        gap = 0;
        first = 1'b1;
        for (int cyc = 0; cyc < 400 && ramp_q.size() > 0; cyc++) begin
            @(posedge clk);
            #1;
            gap++;
            if (int'(duty) != prev_duty) begin
                check_eq("ramp_val", int'(duty), ramp_q.pop_front());
                if (!first) check_eq("ramp_gap", gap, DIV);
                first = 1'b0;
                gap = 0;
                prev_duty = int'(duty);
            end
        end
        if (ramp_q.size() != 0) check_eq("ramp_timeout", ramp_q.size(), 0);
        for (int i = 0; i < 6; i++) tick("ramp_sat", M_CAM, C_FOLLOW, D_FAST, 0, 255, 1);

        // Speed 11: STOP, duty zero one cycle later
        set_in(1'b0, 8'h00, 3'b011, 2'b11, 1'b1);
        tick("stop_cmd", M_CAM, C_FOLLOW, D_STOP, 0, 255, 1);
        tick("stop_duty", M_CAM, C_FOLLOW, D_STOP, 0, 0, 1);

        // Lost-target grace: interrupted low run stays FOLLOW, full run goes SEARCH
        set_in(1'b0, 8'h00, 3'b011, 2'b10, 1'b0);
        for (int i = 0; i < LOST - 2; i++) tick("lost_a", M_CAM, C_FOLLOW, D_FAST, 0, 0, 0);
        orange = 1'b1;
        tick("lost_pulse", M_CAM, C_FOLLOW, D_FAST, 0, 0, 0);
        orange = 1'b0;
        for (int i = 0; i < LOST - 1; i++) tick("lost_b", M_CAM, C_FOLLOW, D_FAST, 0, 0, 0);
        tick("lost_expire", M_CAM, C_SEARCH, D_STOP, 1, 0, 0);

        // Search timeout -> PAUSE
        for (int i = 0; i < SRCH - 1; i++) tick("search", M_CAM, C_SEARCH, D_STOP, 0, 0, 1);
        tick("search_to", M_CAM, C_PAUSE, D_STOP, 1, 0, 1);
        tick("pause_hold", M_CAM, C_PAUSE, D_STOP, 0, 0, 1);
        set_in(1'b1, 8'h10, 3'b011, 2'b10, 1'b0);
        tick("to_idle", M_IDLE, C_PAUSE, D_STOP, 1, 0, 1);

        // IR mode: FAST expires exactly HOLD cycles after the strobe
        set_in(1'b1, 8'h13, 3'b000, 2'b00, 1'b0);
        tick("ir_enter", M_IR, C_PAUSE, D_STOP, 1, 0, 1);
        set_in(1'b1, 8'h02, 3'b000, 2'b00, 1'b0);
        tick("ir_fast", M_IR, C_PAUSE, D_FAST, 0, 0, 1);
        ir_valid = 1'b0;
        for (int i = 0; i < HOLD - 1; i++) tick("ir_hold", M_IR, C_PAUSE, D_FAST, 0, 0, 0);
        tick("ir_expire", M_IR, C_PAUSE, D_STOP, 0, 0, 0);
        tick("ir_exp_duty", M_IR, C_PAUSE, D_STOP, 0, 0, 1);

        // IR LEFT with obstacle overrides; ir_code ignored without ir_valid
        set_in(1'b1, 8'h07, 3'b000, 2'b00, 1'b0);
        tick("ir_left", M_IR, C_PAUSE, D_LEFT, 0, 0, 1);
        set_in(1'b0, 8'h0F, 3'b010, 2'b00, 1'b1);
        tick("ir_hard_l", M_IR, C_PAUSE, D_HARD_L, 0, 0, 0);
        set_in(1'b0, 8'h0F, 3'b010, 2'b00, 1'b0);
        tick("ir_left_back", M_IR, C_PAUSE, D_LEFT, 0, 0, 0);
        set_in(1'b0, 8'h0F, 3'b001, 2'b00, 1'b1);
        tick("ir_hard_r", M_IR, C_PAUSE, D_HARD_R, 0, 0, 0);
        set_in(1'b0, 8'h0F, 3'b011, 2'b00, 1'b1);
        tick("ir_reverse", M_IR, C_PAUSE, D_REVERSE, 0, 0, 0);
        set_in(1'b0, 8'h0F, 3'b011, 2'b11, 1'b1);
        tick("ir_spd_stop", M_IR, C_PAUSE, D_STOP, 0, 0, 0);

        // Mode code and detection together: entry to SEARCH wins
        set_in(1'b1, 8'h0F, 3'b011, 2'b10, 1'b1);
        tick("simul", M_CAM, C_SEARCH, D_STOP, 1, 0, 1);
        ir_valid = 1'b0;
        tick("simul_follow", M_CAM, C_FOLLOW, D_FAST, 1, 0, 1);

        // Asynchronous reset mid-ramp
        for (int i = 0; i < 20 && duty == 0; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("pre_reset_duty_nz", int'(duty != 0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        push(M_IDLE, C_PAUSE, D_STOP, 0, 0, 1);
        pop_cmp("async_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/drive_mode_ctrl.md
Name: drive_mode_ctrl

Overview:
- Parametrised successor to the robot top-level mode FSM; sits between the IR decoder / camera tracker and the motor PWM stage.
- Arbitrates IDLE/CAM/IR modes and CAM sub-states, and produces a drive command plus a ramped duty value.
- Adds behaviour the previous generation lacks: IR dead-man timeout, lost-target grace period, search timeout, one-cycle mode-change pulse, and rate-limited duty with immediate stop.

Parameters:
- CMD_HOLD_CYCLES, 25_000_000: IR motion command expires (drive STOP) this many cycles after the last ir_valid.
- LOST_GRACE_CYCLES, 5_000_000: orange_detected must be low this many consecutive cycles before FOLLOW->SEARCH.
- SEARCH_TIMEOUT_CYCLES, 250_000_000: cycles in SEARCH without detection before entering PAUSE.
- DUTY_W, 8: duty output width.
- RAMP_DIV, 50_000: cycles between duty ramp steps.
- RAMP_STEP, 4: duty increment/decrement per step.

Ports:
- clk_50  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ir_valid  in  1  one-cycle strobe; ir_code is valid this cycle.
- ir_code  in  8  remote button code.
- cam_dir  in  3  001 left, 010 right, 011 centre; other values mean no direction.
- cam_speed  in  2  00 slow, 01 medium, 10 fast, 11 stop.
- orange_detected  in  1  target/obstacle seen.
- mode  out  2  IDLE=00, CAM=01, IR=10.
- cam_state  out  2  SEARCH=00, FOLLOW=01, PAUSE=11.
- drive_state  out  4  STOP 0, LEFT 1, RIGHT 2, SLOW 3, MEDIUM 4, FAST 5, REVERSE 6, LREVERSE 7, RREVERSE 8, HARD_L 9, HARD_R 10.
- mode_change  out  1  one-cycle pulse on any mode or cam_state change.
- duty  out  DUTY_W  ramped motor duty.

Behaviour:
- Reset values (asynchronous on reset_n low): mode=IDLE, cam_state=PAUSE, drive_state=STOP, mode_change=0, duty=0, all counters 0.
- All outputs are registered. Latency from an input to mode, cam_state or drive_state is 1 cycle.
- ir_code is ignored unless ir_valid=1.

Mode transitions (on ir_valid only):
- 0x0F -> CAM; 0x13 -> IR; 0x10 -> IDLE. Any other code leaves mode unchanged.
- Same-mode code: no change and no pulse.

CAM sub-state:
- Entering CAM forces SEARCH and clears the search and lost counters.
- Leaving CAM forces PAUSE.
- SEARCH -> FOLLOW when orange_detected=1.
- SEARCH -> PAUSE when the search counter reaches SEARCH_TIMEOUT_CYCLES-1.
- PAUSE (while in CAM) -> FOLLOW on orange_detected=1.
- FOLLOW -> SEARCH once the lost counter reaches LOST_GRACE_CYCLES-1. Any orange_detected=1 clears the lost counter.

Drive state:
- IDLE: always STOP.
- CAM:
  - cam_speed=11 -> STOP.
  - SEARCH or FOLLOW with dir 001/010 -> LEFT/RIGHT.
  - FOLLOW with dir 011 -> SLOW/MEDIUM/FAST by cam_speed.
  - Otherwise STOP.
- IR, priority high to low:
  1. cam_speed=11 -> STOP.
  2. orange_detected with dir 010/001/011 -> HARD_L/HARD_R/REVERSE.
  3. Latched IR command.
- IR command latch: ir_valid with 0x0C, 07, 09, 02, 05, 08, 00, 11, 17 latches STOP, LEFT, RIGHT, FAST, MEDIUM, SLOW, REVERSE, LREVERSE, RREVERSE respectively, and reloads the hold counter.
  - When the hold counter reaches CMD_HOLD_CYCLES-1 the latch becomes STOP.
  - The latch is cleared to STOP on entry to IR.

mode_change:
- High for exactly the cycle after the registered mode or cam_state changes.

Duty:
- Target per drive_state:
  - SLOW = max/4, MEDIUM = max/2, FAST = max.
  - Turns and reverses = max/2.
  - STOP = 0.
  - max = 2^DUTY_W - 1.
- drive_state=STOP forces duty=0 on the next cycle (no ramp).
- Otherwise, every RAMP_DIV cycles, duty moves RAMP_STEP toward the target, saturating at the target (no overshoot or wrap).
- The divider runs freely and is reset only by reset_n.

Boundaries:
- Simultaneous mode code and orange_detected: the mode change wins and sub-state entry rules apply.
- Counters saturate; they never wrap.
- Reset asserted mid-ramp returns duty to 0 asynchronously.

Decomposition:
- Package drive_pkg holds:
  - mode_t, cam_state_t, drive_state_t enums;
  - IR button code localparams;
  - a function mapping drive_state_t to target duty.
- Sub-module duty_ramp (target in, duty out, RAMP_DIV/RAMP_STEP/DUTY_W parameters) is natural.
- The hex display decode stays outside this block.

Test Plan:
1. Reset, then ir_valid with 0x0F -> mode=01, cam_state=00, and a mode_change pulse of exactly 1 cycle.
2. CAM mode, orange=1, dir=011, speed=10 -> FOLLOW, drive FAST, duty ramps 0->255 in steps of 4, saturating at 255. Then speed=11 -> duty=0 the next cycle.
3. FOLLOW, then orange low for LOST_GRACE-2 cycles, then one high pulse, then low again -> stays FOLLOW. After LOST_GRACE consecutive low cycles -> SEARCH.
4. IR mode, 0x02 -> FAST. No further ir_valid -> STOP exactly CMD_HOLD_CYCLES after the strobe (use small parameters, e.g. 16).
5. IR mode, latched LEFT, orange=1, dir=010 -> HARD_L. Orange drops -> back to LEFT (latch still within hold).
6. SEARCH with no detection for SEARCH_TIMEOUT (e.g. 32) -> PAUSE and a mode_change pulse. Then ir_valid 0x10 -> IDLE and STOP. Reset asserted mid-ramp -> all outputs at reset values immediately.
